// File: rtl/demux2x4_8bits.sv
// Two-lane to four-lane deserializer: rebuilds lanes 0..3 from interleaved even/odd words
// on lanes 00 and 11, locking phase on the first valid lane 00 word after reset.
module demux2x4_8bits #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_2f,
    input  logic          reset_L,
    input  logic [DW-1:0] data_00_cond,
    input  logic          valid_00_cond,
    input  logic [DW-1:0] data_11_cond,
    input  logic          valid_11_cond,
    output logic [DW-1:0] data_0,
    output logic [DW-1:0] data_1,
    output logic [DW-1:0] data_2,
    output logic [DW-1:0] data_3,
    output logic          valid_0,
    output logic          valid_1,
    output logic          valid_2,
    output logic          valid_3,
    output logic          frame_stb,
    output logic          aligned
);

    typedef enum logic [1:0] {StAlign, StRunOdd, StRunEven} state_e;

    state_e state_q, state_d;

    logic [DW-1:0] stage_data_0_q, stage_data_0_d;
    logic [DW-1:0] stage_data_2_q, stage_data_2_d;
    logic          stage_valid_0_q, stage_valid_0_d;
    logic          stage_valid_2_q, stage_valid_2_d;

    logic [DW-1:0] data_0_d, data_1_d, data_2_d, data_3_d;
    logic          valid_0_d, valid_1_d, valid_2_d, valid_3_d;
    logic          frame_stb_d, aligned_d;

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            state_q <= StAlign;
        end else begin
            state_q <= state_d;
        end
    end

    // Once locked the FSM alternates forever; realignment only through reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAlign:   if (valid_00_cond) state_d = StRunOdd;
            StRunOdd:  state_d = StRunEven;
            StRunEven: state_d = StRunOdd;
            default:   state_d = StAlign;
        endcase
    end

    always_comb begin
        stage_data_0_d  = stage_data_0_q;
        stage_data_2_d  = stage_data_2_q;
        stage_valid_0_d = stage_valid_0_q;
        stage_valid_2_d = stage_valid_2_q;
        data_0_d        = data_0;
        data_1_d        = data_1;
        data_2_d        = data_2;
        data_3_d        = data_3;
        valid_0_d       = valid_0;
        valid_1_d       = valid_1;
        valid_2_d       = valid_2;
        valid_3_d       = valid_3;
        frame_stb_d     = frame_stb;
        aligned_d       = aligned;
        unique case (state_q)
            StAlign: begin
                if (valid_00_cond) begin
                    stage_data_0_d  = data_00_cond;
                    stage_data_2_d  = data_11_cond;
                    stage_valid_0_d = valid_00_cond;
                    stage_valid_2_d = valid_11_cond;
                end
            end
            StRunOdd: begin
                // Odd words go straight to the outputs alongside the staged even words.
                data_0_d    = stage_data_0_q;
                data_1_d    = data_00_cond;
                data_2_d    = stage_data_2_q;
                data_3_d    = data_11_cond;
                valid_0_d   = stage_valid_0_q;
                valid_1_d   = valid_00_cond;
                valid_2_d   = stage_valid_2_q;
                valid_3_d   = valid_11_cond;
                frame_stb_d = 1'b1;
                aligned_d   = 1'b1;
            end
            StRunEven: begin
                stage_data_0_d  = data_00_cond;
                stage_data_2_d  = data_11_cond;
                stage_valid_0_d = valid_00_cond;
                stage_valid_2_d = valid_11_cond;
                frame_stb_d     = 1'b0;
            end
            default: begin
                frame_stb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            stage_data_0_q  <= '0;
            stage_data_2_q  <= '0;
            stage_valid_0_q <= 1'b0;
            stage_valid_2_q <= 1'b0;
            data_0          <= '0;
            data_1          <= '0;
            data_2          <= '0;
            data_3          <= '0;
            valid_0         <= 1'b0;
            valid_1         <= 1'b0;
            valid_2         <= 1'b0;
            valid_3         <= 1'b0;
            frame_stb       <= 1'b0;
            aligned         <= 1'b0;
        end else begin
            stage_data_0_q  <= stage_data_0_d;
            stage_data_2_q  <= stage_data_2_d;
            stage_valid_0_q <= stage_valid_0_d;
            stage_valid_2_q <= stage_valid_2_d;
            data_0          <= data_0_d;
            data_1          <= data_1_d;
            data_2          <= data_2_d;
            data_3          <= data_3_d;
            valid_0         <= valid_0_d;
            valid_1         <= valid_1_d;
            valid_2         <= valid_2_d;
            valid_3         <= valid_3_d;
            frame_stb       <= frame_stb_d;
            aligned         <= aligned_d;
        end
    end

endmodule

// File: tb/tb_demux2x4_8bits.sv
// Bench for demux2x4_8bits: expected outputs are derived from the recorded input history
// since reset (lock point, pair boundaries) plus an end-to-end serializer scoreboard.
module tb_demux2x4_8bits;

    logic       clk_2f = 1'b0;
    logic       reset_L;
    logic [7:0] data_00_cond, data_11_cond;
    logic       valid_00_cond, valid_11_cond;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       frame_stb, aligned;

    int tests = 0;
    int fails = 0;

    // Input history since the last reset edge, one entry per clock edge.
    logic [7:0] h00d[$], h11d[$];
    logic       h00v[$], h11v[$];
    int         lock_idx = -1;

    demux2x4_8bits #(.DW(8)) dut (
        .clk_2f        (clk_2f),
        .reset_L       (reset_L),
        .data_00_cond  (data_00_cond),
        .valid_00_cond (valid_00_cond),
        .data_11_cond  (data_11_cond),
        .valid_11_cond (valid_11_cond),
        .data_0        (data_0),
        .data_1        (data_1),
        .data_2        (data_2),
        .data_3        (data_3),
        .valid_0       (valid_0),
        .valid_1       (valid_1),
        .valid_2       (valid_2),
        .valid_3       (valid_3),
        .frame_stb     (frame_stb),
        .aligned       (aligned)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, update history, check against the model.
    task automatic step(input string tag, input logic r, input logic [7:0] d0, input logic v0,
                        input logic [7:0] d1, input logic v1);
        logic [31:0] exp_d;
        logic [5:0]  exp_c;
        int n, k, o, e;
        reset_L       = r;
        data_00_cond  = d0;
        valid_00_cond = v0;
        data_11_cond  = d1;
        valid_11_cond = v1;
        @(posedge clk_2f);
        if (!r) begin
            h00d.delete(); h11d.delete(); h00v.delete(); h11v.delete();
            lock_idx = -1;
        end else begin
            if (lock_idx < 0 && v0) lock_idx = h00d.size();
            h00d.push_back(d0); h00v.push_back(v0);
            h11d.push_back(d1); h11v.push_back(v1);
        end
        #1;
        exp_d = '0;
        exp_c = '0;
        n = h00d.size() - 1;
        if (lock_idx >= 0 && n >= lock_idx + 1) begin
            k = (n - lock_idx - 1) / 2;
            o = lock_idx + 1 + 2 * k;
            e = o - 1;
            exp_d = {h00d[e], h00d[o], h11d[e], h11d[o]};
            exp_c = {h00v[e], h00v[o], h11v[e], h11v[o],
                     1'(((n - lock_idx - 1) % 2) == 0), 1'b1};
        end
        chk({tag, "_data"}, 64'({data_0, data_1, data_2, data_3}), 64'(exp_d));
        chk({tag, "_ctrl"}, 64'({valid_0, valid_1, valid_2, valid_3, frame_stb, aligned}),
            64'(exp_c));
    endtask

    initial begin
        logic [7:0] src_d [4];
        logic       src_v [4];

        // 1. Reset with random inputs
        for (int i = 0; i < 3; i++)
            step("reset", 1'b0, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        chk("reset_aligned", 64'(aligned), 64'(0));

        // 2. Lock sequence
        step("lock", 1'b1, 8'h00, 1'b0, 8'h55, 1'b0);
        step("lock", 1'b1, 8'h00, 1'b0, 8'h66, 1'b1);
        step("lock", 1'b1, 8'hA0, 1'b1, 8'hC2, 1'b1);
        step("lock", 1'b1, 8'hA1, 1'b1, 8'hC3, 1'b1);
        chk("lock_set", 64'({data_0, data_1, data_2, data_3}), 64'(32'hA0A1C2C3));
        chk("lock_stb", 64'({frame_stb, aligned}), 64'(2'b11));

        // 3. Stream of 8 pairs
        for (int i = 0; i < 8; i++) begin
            step("stream", 1'b1, 8'(8'h10 + 2 * i), 1'b1, 8'(8'h20 + 2 * i), 1'b1);
            step("stream", 1'b1, 8'(8'h11 + 2 * i), 1'b1, 8'(8'h21 + 2 * i), 1'b1);
        end

        // 4. Partial valid on lane 11
        step("partial", 1'b1, 8'h31, 1'b1, 8'h42, 1'b1);
        step("partial", 1'b1, 8'h32, 1'b1, 8'h43, 1'b0);
        chk("partial_v23", 64'({valid_2, valid_3}), 64'(2'b10));
        chk("partial_d3", 64'(data_3), 64'(8'h43));

        // 5. Reset mid-pair, then relock after idle cycles
        step("midrst", 1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
        step("midrst", 1'b0, 8'h78, 1'b1, 8'h89, 1'b1);
        chk("midrst_zero", 64'({data_0, data_1, data_2, data_3, frame_stb, aligned}), 64'(0));
        step("relock", 1'b1, 8'h01, 1'b0, 8'h02, 1'b1);
        step("relock", 1'b1, 8'h03, 1'b0, 8'h04, 1'b0);
        step("relock", 1'b1, 8'hB0, 1'b1, 8'hD2, 1'b0);
        step("relock", 1'b1, 8'hB1, 1'b0, 8'hD3, 1'b1);
        chk("relock_set", 64'({data_0, data_1, data_2, data_3}), 64'(32'hB0B1D2D3));

        // Random traffic with random lock point, checked against the history model
        step("rand_rst", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 120; i++)
            step("rand", 1'b1, 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 8'($urandom), 1'($urandom));

        // 6. End-to-end: serialize random 4-lane sets and compare rebuilt sets in order
        step("e2e_rst", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int j = 0; j < 30; j++) begin
            for (int l = 0; l < 4; l++) begin
                src_d[l] = 8'($urandom);
                src_v[l] = 1'($urandom);
            end
            if (j == 0) src_v[0] = 1'b1;
            step("e2e", 1'b1, src_d[0], src_v[0], src_d[2], src_v[2]);
            step("e2e", 1'b1, src_d[1], src_v[1], src_d[3], src_v[3]);
            chk("e2e_set", 64'({data_0, data_1, data_2, data_3,
                                valid_0, valid_1, valid_2, valid_3, frame_stb}),
                64'({src_d[0], src_d[1], src_d[2], src_d[3],
                     src_v[0], src_v[1], src_v[2], src_v[3], 1'b1}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
